// File: rtl/decode_queue.sv
// Instruction FIFO feeding a registered decode stage, with a pending-write scoreboard
// that holds issue on register hazards until writeback.
module decode_queue #(
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned RIDX_W    = 6,
   parameter bit          TRACK_WAW = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_inst,
   input  logic                     flush,
   output logic                     dec_valid,
   input  logic                     dec_ready,
   output logic [3:0]               dec_opcode,
   output logic [2:0]               dec_funct3,
   output logic [6:0]               dec_funct7,
   output logic [RIDX_W-1:0]        dec_rd,
   output logic [RIDX_W-1:0]        dec_rs1,
   output logic [RIDX_W-1:0]        dec_rs2,
   output logic [31:0]              dec_imm,
   output logic [5:0]               dec_ctrl,
   output logic                     dec_endp,
   input  logic                     wb_valid,
   input  logic [RIDX_W-1:0]        wb_rd,
   output logic [(2**RIDX_W)-1:0]   sb_busy
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned NREG  = 2**RIDX_W;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   function automatic logic [31:0] imm_of(input logic [31:0] i);
      case (i[3:0])
         4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd11: imm_of = {{20{i[30]}}, i[30:19]};
         4'd6, 4'd12: imm_of = {{20{i[30]}}, i[30:25], i[9:4]};
         4'd7:        imm_of = {{18{i[30]}}, i[30:25], i[9:4], 2'b00};
         4'd8, 4'd9:  imm_of = {i[29:10], 12'b0};
         default:     imm_of = {{10{i[29]}}, i[29:10], 2'b00};
      endcase
   endfunction

   // {regwrite, alusrc, branch, memwrite, memtoreg, jump}
   function automatic logic [5:0] ctrl_of(input logic [3:0] op);
      case (op)
         4'd0, 4'd8, 4'd9, 4'd13: ctrl_of = 6'b100000;
         4'd1:                    ctrl_of = 6'b110000;
         4'd7:                    ctrl_of = 6'b001000;
         4'd3, 4'd10:             ctrl_of = 6'b110001;
         4'd2, 4'd11:             ctrl_of = 6'b110010;
         4'd6, 4'd12:             ctrl_of = 6'b010100;
         default:                 ctrl_of = 6'b000000;
      endcase
   endfunction

   function automatic logic is_pending(input logic [RIDX_W-1:0] r,
                                       input logic [NREG-1:0]   busy,
                                       input logic              dv,
                                       input logic              dwr,
                                       input logic [RIDX_W-1:0] drd);
      is_pending = (r != '0) && (busy[r] || (dv && dwr && (drd == r)));
   endfunction

   logic [31:0]       mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]    count_q, count_d;
   logic [NREG-1:0]   sb_q, sb_d;

   logic              dec_valid_q;
   logic [31:0]       dec_inst_q;
   logic [31:0]       dec_imm_q;
   logic [5:0]        dec_ctrl_q;

   logic [31:0]       head;
   logic [5:0]        head_ctrl;
   logic [RIDX_W-1:0] head_rd, head_rs1, head_rs2;
   logic              empty, hazard, push, pop, issue;

   assign head      = mem[rd_ptr_q];
   assign head_ctrl = ctrl_of(head[3:0]);
   assign head_rd   = RIDX_W'(head[9:4]);
   assign head_rs1  = RIDX_W'(head[18:13]);
   assign head_rs2  = RIDX_W'(head[24:19]);

   assign empty    = (count_q == '0);
   assign in_ready = (count_q < FULL_CNT);

   // The bundle in the decode register counts as an in-flight write.
   assign hazard = is_pending(head_rs1, sb_q, dec_valid_q, dec_ctrl_q[5], dec_rd)
                || is_pending(head_rs2, sb_q, dec_valid_q, dec_ctrl_q[5], dec_rd)
                || (TRACK_WAW && head_ctrl[5]
                    && is_pending(head_rd, sb_q, dec_valid_q, dec_ctrl_q[5], dec_rd));

   assign push  = in_valid && in_ready && !flush;
   assign pop   = (!dec_valid_q || dec_ready) && !empty && !hazard && !flush;
   assign issue = dec_valid_q && dec_ready && dec_ctrl_q[5] && (dec_rd != '0);

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Set wins over a same-cycle writeback clear of the same index.
   always_comb begin
      sb_d = sb_q;
      if (wb_valid) sb_d[wb_rd] = 1'b0;
      if (issue)    sb_d[dec_rd] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= in_inst;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         sb_q     <= '0;
      end else begin
         sb_q <= sb_d;
         if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dec_valid_q <= 1'b0;
         dec_inst_q  <= '0;
         dec_imm_q   <= '0;
         dec_ctrl_q  <= '0;
      end else if (flush) begin
         dec_valid_q <= 1'b0;
      end else if (pop) begin
         dec_valid_q <= 1'b1;
         dec_inst_q  <= head;
         dec_imm_q   <= imm_of(head);
         dec_ctrl_q  <= head_ctrl;
      end else if (dec_ready) begin
         dec_valid_q <= 1'b0;
      end
   end

   assign dec_valid  = dec_valid_q;
   assign dec_opcode = dec_inst_q[3:0];
   assign dec_funct3 = dec_inst_q[12:10];
   assign dec_funct7 = dec_inst_q[31:25];
   assign dec_rd     = RIDX_W'(dec_inst_q[9:4]);
   assign dec_rs1    = RIDX_W'(dec_inst_q[18:13]);
   assign dec_rs2    = RIDX_W'(dec_inst_q[24:19]);
   assign dec_imm    = dec_imm_q;
   assign dec_ctrl   = dec_ctrl_q;
   assign dec_endp   = (dec_inst_q == 32'd0) && dec_valid_q;
   assign sb_busy    = sb_q;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: table of decode vectors plus hand-written sequences
// for hazards, backpressure, flush, scoreboard races and asynchronous reset.
module tb_decode_queue;
   localparam int NV = 17;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid, in_ready, flush, dec_valid, dec_ready, dec_endp, wb_valid;
   logic [31:0] in_inst, dec_imm;
   logic [3:0]  dec_opcode;
   logic [2:0]  dec_funct3;
   logic [6:0]  dec_funct7;
   logic [5:0]  dec_rd, dec_rs1, dec_rs2, dec_ctrl, wb_rd;
   logic [63:0] sb_busy;

   int n_pass = 0;
   int n_total = 0;

   typedef struct {
      logic [31:0] inst;
      logic [3:0]  op;
      logic [5:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic [5:0]  ctrl;
      logic        endp;
   } vec_t;
   vec_t vecs [NV];

   decode_queue #(.DEPTH(4), .RIDX_W(6), .TRACK_WAW(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
      .flush(flush), .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_opcode(dec_opcode),
      .dec_funct3(dec_funct3), .dec_funct7(dec_funct7), .dec_rd(dec_rd), .dec_rs1(dec_rs1),
      .dec_rs2(dec_rs2), .dec_imm(dec_imm), .dec_ctrl(dec_ctrl), .dec_endp(dec_endp),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .sb_busy(sb_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Called at a negedge; enqueue spans one posedge and returns at the next negedge.
   task automatic push(input logic [31:0] inst);
      in_valid = 1'b1;
      in_inst  = inst;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_dv(input string name, input int max);
      int n = 0;
      while (!dec_valid && n < max) begin
         @(negedge clk);
         n++;
      end
      chk({name, " arrives"}, 64'(dec_valid), 64'd1);
   endtask

   function automatic vec_t mk(input logic [31:0] inst, input logic [3:0] op,
                               input logic [5:0] rd, input logic [5:0] rs1,
                               input logic [5:0] rs2, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [31:0] imm,
                               input logic [5:0] ctrl, input logic endp);
      vec_t v;
      v.inst = inst; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
      v.f3 = f3; v.f7 = f7; v.imm = imm; v.ctrl = ctrl; v.endp = endp;
      return v;
   endfunction

   initial begin
      logic [63:0] exp_sb;
      int got;

      //              inst          op     rd  rs1 rs2 f3 f7     imm           ctrl        endp
      vecs[0]  = mk(32'h00000000, 4'd0,  0,  0,  0,  0, 7'h00, 32'h00000000, 6'b100000, 1);
      vecs[1]  = mk(32'h00202011, 4'd1,  1,  1,  4,  0, 7'h00, 32'h00000004, 6'b110000, 0);
      vecs[2]  = mk(32'hC0000005, 4'd5,  0,  0,  0,  0, 7'h60, 32'hFFFFF800, 6'b000000, 0);
      vecs[3]  = mk(32'h06000056, 4'd6,  5,  0,  0,  0, 7'h03, 32'h000000C5, 6'b010100, 0);
      vecs[4]  = mk(32'h40000017, 4'd7,  1,  0,  0,  0, 7'h20, 32'hFFFFE004, 6'b001000, 0);
      vecs[5]  = mk(32'h2AF37808, 4'd8,  0, 27, 30,  6, 7'h15, 32'hABCDE000, 6'b100000, 0);
      vecs[6]  = mk(32'h2000000E, 4'd14, 0,  0,  0,  0, 7'h10, 32'hFFE00000, 6'b000000, 0);
      vecs[7]  = mk(32'h00080073, 4'd3,  7,  0,  1,  0, 7'h00, 32'h00000001, 6'b110001, 0);
      vecs[8]  = mk(32'h00000002, 4'd2,  0,  0,  0,  0, 7'h00, 32'h00000000, 6'b110010, 0);
      vecs[9]  = mk(32'h0000000A, 4'd10, 0,  0,  0,  0, 7'h00, 32'h00000000, 6'b110001, 0);
      vecs[10] = mk(32'h0000000D, 4'd13, 0,  0,  0,  0, 7'h00, 32'h00000000, 6'b100000, 0);
      vecs[11] = mk(32'h0000000C, 4'd12, 0,  0,  0,  0, 7'h00, 32'h00000000, 6'b010100, 0);
      vecs[12] = mk(32'h0000000B, 4'd11, 0,  0,  0,  0, 7'h00, 32'h00000000, 6'b110010, 0);
      vecs[13] = mk(32'h00000009, 4'd9,  0,  0,  0,  0, 7'h00, 32'h00000000, 6'b100000, 0);
      vecs[14] = mk(32'h00000004, 4'd4,  0,  0,  0,  0, 7'h00, 32'h00000000, 6'b000000, 0);
      vecs[15] = mk(32'h0000000F, 4'd15, 0,  0,  0,  0, 7'h00, 32'h00000000, 6'b000000, 0);
      vecs[16] = mk(32'hFE001C01, 4'd1,  0,  0,  0,  7, 7'h7F, 32'hFFFFFFC0, 6'b110000, 0);

      in_valid = 0; in_inst = '0; flush = 0; dec_ready = 0; wb_valid = 0; wb_rd = '0;

      // Reset state
      #1;
      chk("rst dec_valid", 64'(dec_valid), 64'd0);
      chk("rst fields", 64'({dec_opcode, dec_rd, dec_rs1, dec_rs2, dec_funct3, dec_funct7}), 64'd0);
      chk("rst imm/ctrl/endp", 64'({dec_imm, dec_ctrl, dec_endp}), 64'd0);
      chk("rst sb_busy", sb_busy, 64'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      chk("rst in_ready", 64'(in_ready), 64'd1);

      // Decode table: one instruction at a time, issue, then retire its write
      for (int i = 0; i < NV; i++) begin
         push(vecs[i].inst);
         chk($sformatf("v%0d not yet valid", i), 64'(dec_valid), 64'd0);
         @(negedge clk);
         chk($sformatf("v%0d valid", i), 64'(dec_valid), 64'd1);
         chk($sformatf("v%0d fields", i),
             64'({dec_opcode, dec_rd, dec_rs1, dec_rs2, dec_funct3, dec_funct7}),
             64'({vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].f3, vecs[i].f7}));
         chk($sformatf("v%0d imm", i), 64'(dec_imm), 64'(vecs[i].imm));
         chk($sformatf("v%0d ctrl", i), 64'(dec_ctrl), 64'(vecs[i].ctrl));
         chk($sformatf("v%0d endp", i), 64'(dec_endp), 64'(vecs[i].endp));
         dec_ready = 1'b1;
         @(negedge clk);
         dec_ready = 1'b0;
         chk($sformatf("v%0d drained", i), 64'(dec_valid), 64'd0);
         exp_sb = '0;
         if (vecs[i].ctrl[5] && vecs[i].rd != 0) exp_sb[vecs[i].rd] = 1'b1;
         chk($sformatf("v%0d sb set", i), sb_busy, exp_sb);
         wb_valid = 1'b1; wb_rd = vecs[i].rd;
         @(negedge clk);
         wb_valid = 1'b0;
         chk($sformatf("v%0d sb clear", i), sb_busy, 64'd0);
      end

      // RAW: writer rd=5 then reader rs1=5
      dec_ready = 1'b1;
      push(32'h00000051);
      push(32'h0000A006);
      chk("raw writer", 64'({dec_valid, dec_rd}), 64'({1'b1, 6'd5}));
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("raw held %0d", c), 64'(dec_valid), 64'd0);
      end
      chk("raw sb5", sb_busy, 64'd1 << 5);
      wb_valid = 1'b1; wb_rd = 6'd5;
      @(negedge clk);
      wb_valid = 1'b0;
      wait_dv("raw reader", 3);
      chk("raw reader fields", 64'({dec_opcode, dec_rs1}), 64'({4'd6, 6'd5}));
      @(negedge clk);
      chk("raw reader issued", 64'({dec_valid, sb_busy[5]}), 64'd0);
      dec_ready = 1'b0;

      // Backpressure fill: 4 in FIFO + 1 in decode register
      for (int k = 1; k <= 5; k++) begin
         chk($sformatf("fill in_ready %0d", k), 64'(in_ready), 64'd1);
         push(32'(k * 16 + 4));
      end
      chk("fill full", 64'(in_ready), 64'd0);
      in_valid = 1'b1; in_inst = 32'h00000064;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk($sformatf("fill stable %0d", c), 64'({dec_valid, dec_rd, in_ready}),
             64'({1'b1, 6'd1, 1'b0}));
      end
      in_valid = 1'b0;
      dec_ready = 1'b1;
      @(negedge clk);
      dec_ready = 1'b0;
      chk("pulse in_ready", 64'(in_ready), 64'd1);
      chk("pulse next", 64'(dec_rd), 64'd2);
      // Drain at full rate while adding one more across the pointer wrap
      dec_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h00000064;
      got = 0;
      for (int c = 0; c < 10; c++) begin
         if (dec_valid) begin
            chk($sformatf("order %0d", got), 64'(dec_rd), 64'(got + 2));
            got++;
         end
         @(negedge clk);
         in_valid = 1'b0;
      end
      chk("order count", 64'(got), 64'd5);
      dec_ready = 1'b0;

      // Flush with a live scoreboard bit, 3 queued and an issuing bundle
      dec_ready = 1'b1;
      push(32'h00000091);
      @(negedge clk); @(negedge clk);
      dec_ready = 1'b0;
      chk("pre-flush sb9", sb_busy, 64'd1 << 9);
      push(32'h000000A1); push(32'h00000024); push(32'h00000034); push(32'h00000044);
      chk("pre-flush dec", 64'({dec_valid, dec_rd}), 64'({1'b1, 6'd10}));
      flush = 1'b1; dec_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h00000055;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      chk("flush dec_valid", 64'(dec_valid), 64'd0);
      chk("flush sb", sb_busy, (64'd1 << 9) | (64'd1 << 10));
      chk("flush in_ready", 64'(in_ready), 64'd1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("flush empty %0d", c), 64'(dec_valid), 64'd0);
      end

      // WAW: head writes rd=9 while 9 is pending
      push(32'h00000091);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("waw held %0d", c), 64'(dec_valid), 64'd0);
      end
      wb_valid = 1'b1; wb_rd = 6'd9;
      @(negedge clk);
      wb_valid = 1'b0;
      wait_dv("waw writer", 3);
      chk("waw rd", 64'(dec_rd), 64'd9);
      @(negedge clk);
      wb_valid = 1'b1; wb_rd = 6'd9;
      @(negedge clk);
      wb_rd = 6'd10;
      @(negedge clk);
      wb_valid = 1'b0;
      dec_ready = 1'b0;
      chk("waw sb clean", sb_busy, 64'd0);

      // Same-cycle set and clear of rd=7, then idle clear
      push(32'h00000071);
      @(negedge clk);
      chk("race valid", 64'({dec_valid, dec_rd}), 64'({1'b1, 6'd7}));
      dec_ready = 1'b1; wb_valid = 1'b1; wb_rd = 6'd7;
      @(negedge clk);
      dec_ready = 1'b0;
      chk("race set wins", sb_busy, 64'd1 << 7);
      wb_rd = 6'd20;
      @(negedge clk);
      chk("idle clear", sb_busy, 64'd1 << 7);
      wb_rd = 6'd7;
      @(negedge clk);
      wb_valid = 1'b0;
      chk("clear 7", sb_busy, 64'd0);

      // Asynchronous reset mid-operation
      push(32'h00000081); push(32'h00000024); push(32'h00000034);
      dec_ready = 1'b1;
      @(negedge clk);
      dec_ready = 1'b0;
      chk("pre-rst state", 64'({dec_valid, dec_rd, sb_busy[8]}), 64'({1'b1, 6'd2, 1'b1}));
      #2 rst = 1'b1;
      #1;
      chk("async rst dec", 64'({dec_valid, dec_rd, dec_ctrl}), 64'd0);
      chk("async rst sb", sb_busy, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      dec_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("post-rst empty %0d", c), 64'({dec_valid, in_ready}), 64'({1'b0, 1'b1}));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, got running, expected done");
      $fatal(1, "watchdog");
   end

endmodule
